// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time,
// steers the PC register, and delivers fetched words into a single IF/ID slot
// with a one-entry hold buffer for words that return while decode is stalled.
module fetch_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              resetActiveLow,
   input  logic [31:0]       programCounter,
   output logic [31:0]       nextProgramCounter,
   output logic              pcEnable,
   output logic              imemRequestValid,
   output logic [31:0]       imemRequestAddress,
   input  logic              imemRequestReady,
   input  logic              imemResponseValid,
   input  logic [DATA_W-1:0] imemResponseData,
   input  logic              redirectValid,
   input  logic [31:0]       redirectTarget,
   input  logic              decodeStall,
   output logic              fetchedValid,
   output logic [DATA_W-1:0] fetchedInstruction,
   output logic [31:0]       fetchedProgramCounter
);

   typedef enum logic [1:0] {
      REQUEST = 2'd0,
      WAIT    = 2'd1,
      HOLD    = 2'd2,
      DRAIN   = 2'd3
   } fetchState_t;

   fetchState_t       state;
   fetchState_t       stateNext;

   logic [31:0]       pendingPc;
   logic [DATA_W-1:0] holdInstruction;
   logic [31:0]       holdProgramCounter;

   logic              accept;
   logic              consume;
   logic              slotFree;
   logic              loadFromResponse;
   logic              loadFromHold;
   logic              captureHold;

   // Next-state selection plus the combinational request/PC-steering outputs.
   always_comb begin
      stateNext          = state;
      loadFromResponse   = 1'b0;
      loadFromHold       = 1'b0;
      captureHold        = 1'b0;

      // Request and PC strobes are gated so nothing leaks out while reset is held.
      imemRequestValid   = resetActiveLow && (state == REQUEST);
      imemRequestAddress = programCounter;
      accept             = imemRequestValid && imemRequestReady;
      pcEnable           = resetActiveLow && (accept || redirectValid);

      // A redirect always wins over the sequential +4 step, even on an accept cycle.
      if (redirectValid) begin
         nextProgramCounter = redirectTarget & 32'hFFFF_FFFC;
      end else begin
         nextProgramCounter = programCounter + 32'd4;
      end

      consume  = fetchedValid && !decodeStall;
      slotFree = !fetchedValid || consume;

      case (state)
         REQUEST: begin
            // A request that leaves on a redirect cycle is stale; its reply must be drained.
            if (accept) begin
               stateNext = redirectValid ? DRAIN : WAIT;
            end
         end
         WAIT: begin
            if (imemResponseValid) begin
               if (redirectValid) begin
                  stateNext = REQUEST;
               end else if (slotFree) begin
                  stateNext        = REQUEST;
                  loadFromResponse = 1'b1;
               end else begin
                  stateNext   = HOLD;
                  captureHold = 1'b1;
               end
            end else if (redirectValid) begin
               stateNext = DRAIN;
            end
         end
         HOLD: begin
            // Leaving HOLD on a redirect is what discards the held word.
            if (redirectValid) begin
               stateNext = REQUEST;
            end else if (!decodeStall) begin
               stateNext    = REQUEST;
               loadFromHold = 1'b1;
            end
         end
         DRAIN: begin
            if (imemResponseValid) begin
               stateNext = REQUEST;
            end
         end
         default: begin
            stateNext = REQUEST;
         end
      endcase
   end

   // FSM state register; reset abandons any outstanding request.
   always_ff @(posedge clock or negedge resetActiveLow) begin
      if (!resetActiveLow) begin
         state <= REQUEST;
      end else begin
         state <= stateNext;
      end
   end

   // Remember the address of the request in flight so its word can be tagged.
   always_ff @(posedge clock or negedge resetActiveLow) begin
      if (!resetActiveLow) begin
         pendingPc <= 32'h0000_0000;
      end else if (accept) begin
         pendingPc <= imemRequestAddress;
      end
   end

   // One-entry hold buffer for a word that arrives while the IF/ID slot is busy.
   always_ff @(posedge clock or negedge resetActiveLow) begin
      if (!resetActiveLow) begin
         holdInstruction    <= '0;
         holdProgramCounter <= 32'h0000_0000;
      end else if (captureHold) begin
         holdInstruction    <= imemResponseData;
         holdProgramCounter <= pendingPc;
      end
   end

   // IF/ID slot: redirect flushes, then a new word loads, otherwise a consume empties it.
   always_ff @(posedge clock or negedge resetActiveLow) begin
      if (!resetActiveLow) begin
         fetchedValid          <= 1'b0;
         fetchedInstruction    <= '0;
         fetchedProgramCounter <= 32'h0000_0000;
      end else if (redirectValid) begin
         fetchedValid <= 1'b0;
      end else if (loadFromResponse) begin
         fetchedValid          <= 1'b1;
         fetchedInstruction    <= imemResponseData;
         fetchedProgramCounter <= pendingPc;
      end else if (loadFromHold) begin
         fetchedValid          <= 1'b1;
         fetchedInstruction    <= holdInstruction;
         fetchedProgramCounter <= holdProgramCounter;
      end else if (consume) begin
         fetchedValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        resetActiveLow = 1'b1;
   logic [31:0] programCounter = 32'h0;
   logic [31:0] nextProgramCounter;
   logic        pcEnable;
   logic        imemRequestValid;
   logic [31:0] imemRequestAddress;
   logic        imemRequestReady = 1'b0;
   logic        imemResponseValid = 1'b0;
   logic [31:0] imemResponseData = 32'h0;
   logic        redirectValid = 1'b0;
   logic [31:0] redirectTarget = 32'h0;
   logic        decodeStall = 1'b0;
   logic        fetchedValid;
   logic [31:0] fetchedInstruction;
   logic [31:0] fetchedProgramCounter;

   fetch_unit dut (
      .clock                 (clock),
      .resetActiveLow        (resetActiveLow),
      .programCounter        (programCounter),
      .nextProgramCounter    (nextProgramCounter),
      .pcEnable              (pcEnable),
      .imemRequestValid      (imemRequestValid),
      .imemRequestAddress    (imemRequestAddress),
      .imemRequestReady      (imemRequestReady),
      .imemResponseValid     (imemResponseValid),
      .imemResponseData      (imemResponseData),
      .redirectValid         (redirectValid),
      .redirectTarget        (redirectTarget),
      .decodeStall           (decodeStall),
      .fetchedValid          (fetchedValid),
      .fetchedInstruction    (fetchedInstruction),
      .fetchedProgramCounter (fetchedProgramCounter)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Transaction-level model: one request in flight (possibly marked for
   // dropping), an optional parked word, and the IF/ID slot contents.
   logic        mInFlight = 1'b0;
   logic        mDrop = 1'b0;
   logic [31:0] mPending = 32'h0;
   logic        mHeld = 1'b0;
   logic [31:0] mHeldInstr = 32'h0;
   logic [31:0] mHeldPc = 32'h0;
   logic        mSlotValid = 1'b0;
   logic [31:0] mSlotInstr = 32'h0;
   logic [31:0] mSlotPc = 32'h0;
   logic        mCanIssue;
   logic        mAccept;
   logic        mConsume;
   logic        mSlotOpen;

   always @(negedge clock) begin
      if (!resetActiveLow) begin
         mInFlight  = 1'b0;
         mDrop      = 1'b0;
         mHeld      = 1'b0;
         mSlotValid = 1'b0;
      end else begin
         mCanIssue = !mInFlight && !mHeld;
         mAccept   = mCanIssue && imemRequestReady;
         checkBit("model.requestValid", imemRequestValid, mCanIssue);
         if (mCanIssue) checkWord("model.requestAddress", imemRequestAddress, programCounter);
         checkBit("model.pcEnable", pcEnable, mAccept || redirectValid);
         if (redirectValid)
            checkWord("model.nextPcRedirect", nextProgramCounter, {redirectTarget[31:2], 2'b00});
         else if (mAccept)
            checkWord("model.nextPcStep", nextProgramCounter, programCounter + 32'd4);
         checkBit("model.fetchedValid", fetchedValid, mSlotValid);
         if (mSlotValid) begin
            checkWord("model.fetchedInstruction", fetchedInstruction, mSlotInstr);
            checkWord("model.fetchedPc", fetchedProgramCounter, mSlotPc);
         end

         mConsume  = mSlotValid && !decodeStall;
         mSlotOpen = !mSlotValid || mConsume;
         if (redirectValid) begin
            mSlotValid = 1'b0;
            mHeld      = 1'b0;
            if (mInFlight) begin
               if (imemResponseValid) mInFlight = 1'b0;
               else mDrop = 1'b1;
            end
            if (mAccept) begin
               mInFlight = 1'b1;
               mDrop     = 1'b1;
               mPending  = programCounter;
            end
         end else begin
            if (mConsume) mSlotValid = 1'b0;
            if (mInFlight && imemResponseValid) begin
               mInFlight = 1'b0;
               if (!mDrop) begin
                  if (mSlotOpen) begin
                     mSlotValid = 1'b1;
                     mSlotInstr = imemResponseData;
                     mSlotPc    = mPending;
                  end else begin
                     mHeld      = 1'b1;
                     mHeldInstr = imemResponseData;
                     mHeldPc    = mPending;
                  end
               end
            end else if (mHeld && !decodeStall) begin
               mHeld      = 1'b0;
               mSlotValid = 1'b1;
               mSlotInstr = mHeldInstr;
               mSlotPc    = mHeldPc;
            end
            if (mAccept) begin
               mInFlight = 1'b1;
               mDrop     = 1'b0;
               mPending  = programCounter;
            end
         end
      end
   end

   // Environment: the bench plays the PC register and the instruction memory.
   logic        smpEn;
   logic        smpAcc;
   logic [31:0] smpNext;
   logic        memBusy = 1'b0;
   int unsigned memDelay = 0;

   task automatic tick();
      @(negedge clock);
      smpEn   = pcEnable;
      smpNext = nextProgramCounter;
      smpAcc  = imemRequestValid && imemRequestReady;
      @(posedge clock);
      #1;
      if (smpEn) programCounter = smpNext;
   endtask

   task automatic applyReset(input logic [31:0] startPc);
      @(posedge clock);
      #3;
      resetActiveLow    = 1'b0;
      imemRequestReady  = 1'b0;
      imemResponseValid = 1'b0;
      imemResponseData  = 32'h0;
      redirectValid     = 1'b0;
      redirectTarget    = 32'h0;
      decodeStall       = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      resetActiveLow = 1'b1;
      programCounter = startPc;
   endtask

   initial begin
      // Reset values
      #1 resetActiveLow = 1'b0;
      #2;
      checkBit("reset.fetchedValid", fetchedValid, 1'b0);
      checkBit("reset.pcEnable", pcEnable, 1'b0);
      checkBit("reset.requestValid", imemRequestValid, 1'b0);
      checkWord("reset.fetchedInstruction", fetchedInstruction, 32'h0);
      checkWord("reset.fetchedPc", fetchedProgramCounter, 32'h0);
      repeat (2) @(posedge clock);
      #1 resetActiveLow = 1'b1;

      // Straight-line fetch from PC 0
      applyReset(32'h0);
      imemRequestReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkBit("line.requestValid", imemRequestValid, 1'b1);
         checkWord("line.requestAddress", imemRequestAddress, 32'(4 * i));
         checkBit("line.pcEnable", pcEnable, 1'b1);
         checkWord("line.nextPc", nextProgramCounter, 32'(4 * i + 4));
         if (i > 0) checkWord("line.fetchedPc", fetchedProgramCounter, 32'(4 * (i - 1)));
         tick();
         imemResponseValid = 1'b1;
         imemResponseData  = 32'hA000_0000 + 32'(i);
         #1;
         checkBit("line.pcEnableIdle", pcEnable, 1'b0);
         tick();
         imemResponseValid = 1'b0;
      end
      #1;
      checkBit("line.lastValid", fetchedValid, 1'b1);
      checkWord("line.lastPc", fetchedProgramCounter, 32'h8);
      checkWord("line.lastInstruction", fetchedInstruction, 32'hA000_0002);

      // Decode stall parks the returning word, release delivers it
      applyReset(32'h100);
      imemRequestReady = 1'b1;
      tick();
      imemResponseValid = 1'b1;
      imemResponseData  = 32'h1111_1111;
      tick();
      imemResponseValid = 1'b0;
      decodeStall       = 1'b1;
      tick();
      imemResponseValid = 1'b1;
      imemResponseData  = 32'h0000_0013;
      tick();
      imemResponseValid = 1'b0;
      #1;
      checkBit("stall.requestValid", imemRequestValid, 1'b0);
      checkBit("stall.slotValid", fetchedValid, 1'b1);
      checkWord("stall.slotUnchanged", fetchedInstruction, 32'h1111_1111);
      tick();
      #1;
      checkBit("stall.stillHeld", imemRequestValid, 1'b0);
      decodeStall = 1'b0;
      tick();
      #1;
      checkBit("stall.releaseValid", fetchedValid, 1'b1);
      checkWord("stall.releaseInstruction", fetchedInstruction, 32'h0000_0013);
      checkWord("stall.releasePc", fetchedProgramCounter, 32'h104);

      // Redirect while waiting on a response
      applyReset(32'h10);
      imemRequestReady = 1'b1;
      #1;
      checkWord("redirWait.requestAddress", imemRequestAddress, 32'h10);
      tick();
      redirectValid  = 1'b1;
      redirectTarget = 32'h203;
      #1;
      checkBit("redirWait.pcEnable", pcEnable, 1'b1);
      checkWord("redirWait.nextPc", nextProgramCounter, 32'h200);
      checkBit("redirWait.noRequest", imemRequestValid, 1'b0);
      tick();
      redirectValid = 1'b0;
      #1;
      checkBit("redirWait.drainNoRequest", imemRequestValid, 1'b0);
      tick();
      imemResponseValid = 1'b1;
      imemResponseData  = 32'hDEAD_BEEF;
      #1;
      checkBit("redirWait.drainResponse", imemRequestValid, 1'b0);
      tick();
      imemResponseValid = 1'b0;
      #1;
      checkBit("redirWait.discarded", fetchedValid, 1'b0);
      checkBit("redirWait.newRequest", imemRequestValid, 1'b1);
      checkWord("redirWait.newAddress", imemRequestAddress, 32'h200);

      // Accept and redirect in the same cycle
      applyReset(32'h40);
      imemRequestReady = 1'b1;
      redirectValid    = 1'b1;
      redirectTarget   = 32'h81;
      #1;
      checkBit("redirAcc.requestValid", imemRequestValid, 1'b1);
      checkBit("redirAcc.pcEnable", pcEnable, 1'b1);
      checkWord("redirAcc.nextPc", nextProgramCounter, 32'h80);
      tick();
      redirectValid     = 1'b0;
      imemResponseValid = 1'b1;
      imemResponseData  = 32'hBAD0_0001;
      #1;
      checkBit("redirAcc.drain", imemRequestValid, 1'b0);
      tick();
      imemResponseValid = 1'b0;
      #1;
      checkBit("redirAcc.discarded", fetchedValid, 1'b0);
      checkWord("redirAcc.targetAddress", imemRequestAddress, 32'h80);
      tick();
      imemResponseValid = 1'b1;
      imemResponseData  = 32'h0000_0055;
      tick();
      imemResponseValid = 1'b0;
      #1;
      checkBit("redirAcc.validAfter", fetchedValid, 1'b1);
      checkWord("redirAcc.instrAfter", fetchedInstruction, 32'h55);
      checkWord("redirAcc.pcAfter", fetchedProgramCounter, 32'h80);

      // PC wrap-around
      applyReset(32'hFFFF_FFFC);
      imemRequestReady = 1'b1;
      #1;
      checkBit("wrap.pcEnable", pcEnable, 1'b1);
      checkWord("wrap.nextPc", nextProgramCounter, 32'h0);
      tick();
      imemResponseValid = 1'b1;
      imemResponseData  = 32'h0000_0077;
      tick();
      imemResponseValid = 1'b0;
      #1;
      checkWord("wrap.fetchedPc", fetchedProgramCounter, 32'hFFFF_FFFC);
      checkWord("wrap.requestAddress", imemRequestAddress, 32'h0);

      // Randomized traffic against the model
      applyReset($urandom & 32'hFFFF_FFFC);
      memBusy = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         imemResponseValid = 1'b0;
         imemResponseData  = $urandom;
         if (memBusy) begin
            if (memDelay == 0) begin
               imemResponseValid = 1'b1;
               memBusy = 1'b0;
            end else begin
               memDelay--;
            end
         end else if ($urandom_range(0, 7) == 0) begin
            imemResponseValid = 1'b1;
         end
         imemRequestReady = ($urandom_range(0, 3) != 0);
         decodeStall      = ($urandom_range(0, 2) == 0);
         redirectValid    = ($urandom_range(0, 11) == 0);
         redirectTarget   = $urandom;
         if ($urandom_range(0, 63) == 0) programCounter = 32'hFFFF_FFF8;
         tick();
         if (smpAcc) begin
            memBusy  = 1'b1;
            memDelay = $urandom_range(0, 3);
         end
      end

      // Reset asserted while a request is outstanding
      applyReset(32'h300);
      imemRequestReady = 1'b1;
      tick();
      imemResponseValid = 1'b1;
      imemResponseData  = 32'h0000_0099;
      tick();
      imemResponseValid = 1'b0;
      decodeStall       = 1'b1;
      tick();
      #1;
      checkBit("rstWait.preValid", fetchedValid, 1'b1);
      checkBit("rstWait.preNoRequest", imemRequestValid, 1'b0);
      #1 resetActiveLow = 1'b0;
      #1;
      checkBit("rstWait.fetchedValid", fetchedValid, 1'b0);
      checkBit("rstWait.pcEnable", pcEnable, 1'b0);
      checkBit("rstWait.requestValid", imemRequestValid, 1'b0);
      checkWord("rstWait.fetchedInstruction", fetchedInstruction, 32'h0);
      checkWord("rstWait.fetchedPc", fetchedProgramCounter, 32'h0);
      repeat (2) @(posedge clock);
      #1;
      resetActiveLow    = 1'b1;
      decodeStall       = 1'b0;
      imemRequestReady  = 1'b0;
      imemResponseValid = 1'b1;
      imemResponseData  = 32'h0000_1234;
      #1;
      checkBit("rstWait.firstRequest", imemRequestValid, 1'b1);
      checkWord("rstWait.firstAddress", imemRequestAddress, 32'h308);
      tick();
      imemResponseValid = 1'b0;
      #1;
      checkBit("rstWait.staleIgnored", fetchedValid, 1'b0);
      checkBit("rstWait.stillRequesting", imemRequestValid, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, as listed below.
- clock  in  1  rising-edge clock
- resetActiveLow  in  1  asynchronous, active-low reset
REQ-002 The block SHALL have the following PC-register ports.
- programCounter  in  32  current PC from the PC register
- nextProgramCounter  out  32  value the PC register loads
- pcEnable  out  1  PC register load enable
REQ-003 The block SHALL have the following instruction-memory ports.
- imemRequestValid  out  1  fetch request valid
- imemRequestAddress  out  32  fetch address
- imemRequestReady  in  1  memory accepts request
- imemResponseValid  in  1  instruction word returned
- imemResponseData  in  32  instruction word
REQ-004 The block SHALL have the following control and decode ports.
- redirectValid  in  1  branch/jump redirect
- redirectTarget  in  32  redirect address
- decodeStall  in  1  decode cannot accept this cycle
- fetchedValid  out  1  IF/ID slot holds an instruction
- fetchedInstruction  out  32  IF/ID instruction
- fetchedProgramCounter  out  32  PC of fetchedInstruction

Function
REQ-005 The FSM SHALL have four states: REQUEST, WAIT, HOLD, DRAIN.
REQ-006 At most one memory request SHALL be outstanding.
REQ-007 In REQUEST, imemRequestValid SHALL be 1 and imemRequestAddress SHALL equal programCounter.
- In all other states, imemRequestValid SHALL be 0.
REQ-008 A request SHALL be accepted on a cycle with imemRequestValid=1 and imemRequestReady=1. On accept, the block SHALL:
- latch the address into pendingPc;
- drive pcEnable=1 and nextProgramCounter=programCounter+4 (mod 2^32, wrapping 0xFFFFFFFC to 0x00000000);
- go to WAIT.
REQ-009 Outside accept and redirect cycles, pcEnable SHALL be 0.
REQ-010 A decode consume SHALL occur when fetchedValid=1 and decodeStall=0. The IF/ID slot is free when fetchedValid=0 or a consume occurs that cycle.
REQ-011 WAIT with imemResponseValid=1 and the slot free SHALL:
- load fetchedInstruction=imemResponseData and fetchedProgramCounter=pendingPc;
- set fetchedValid=1;
- go to REQUEST.
REQ-012 WAIT with imemResponseValid=1 and the slot not free SHALL capture the word and pendingPc into a one-entry hold buffer and go to HOLD.
REQ-013 In HOLD, when decodeStall=0, the hold buffer SHALL move into the IF/ID slot (fetchedValid stays 1), and the FSM SHALL go to REQUEST.
REQ-014 A consume with no new load SHALL clear fetchedValid next cycle.
REQ-015 Output latency SHALL be one cycle: a response in cycle N SHALL appear on the fetched outputs in cycle N+1 when the slot is free.
REQ-016 redirectValid=1 SHALL have highest priority. In that cycle, the block SHALL:
- drive pcEnable=1 and nextProgramCounter={redirectTarget[31:2],2'b00};
- clear fetchedValid and discard the hold buffer next cycle.
REQ-017 On redirect, the next state SHALL be:
- from REQUEST without accept: REQUEST;
- from REQUEST with accept in the same cycle: DRAIN (PC takes the target, not +4);
- from WAIT without response: DRAIN;
- from WAIT with response in the same cycle: REQUEST, and the response SHALL be discarded;
- from HOLD: REQUEST;
- from DRAIN: DRAIN.
REQ-018 In DRAIN, the next imemResponseValid SHALL be discarded and the FSM SHALL go to REQUEST. A redirect in that same cycle still updates the PC.
REQ-019 In any state other than WAIT or DRAIN, imemResponseValid SHALL be ignored.

Reset
REQ-020 While resetActiveLow=0, outputs SHALL be:
- FSM state: REQUEST;
- fetchedValid, pcEnable, imemRequestValid: 0;
- fetchedInstruction, fetchedProgramCounter, pendingPc, hold buffer: 0x00000000.
REQ-021 Reset assertion mid-request SHALL abandon the outstanding request. A response arriving after reset release while in REQUEST SHALL be ignored per REQ-019.

Verification
REQ-022 Straight-line fetch: PC=0, ready=1, response always one cycle after accept, no stall -> fetchedProgramCounter sequence 0x0, 0x4, 0x8, with pcEnable pulsing on each accept.
REQ-023 Stall: fetchedValid=1 and decodeStall=1 while a response of 0x00000013 arrives -> state HOLD, no request issued; release the stall -> the slot shows 0x00000013 on the next cycle.
REQ-024 Redirect in WAIT: request to 0x10 accepted, redirectValid=1 with target 0x203 -> nextProgramCounter=0x200, DRAIN; the response for 0x10 never appears on the fetched outputs; the next request address is 0x200.
REQ-025 Simultaneous accept and redirect in REQUEST -> pcEnable=1, nextProgramCounter=target; the following response is discarded.
REQ-026 Wrap-around: PC=0xFFFFFFFC accepted -> nextProgramCounter=0x00000000.
REQ-027 Reset asserted in WAIT -> all outputs reach their REQ-020 values asynchronously; after release, the first request address equals programCounter.
